fu_alu_issue: RTL and testbench
===============================

FU_ALU_ISSUE -- requirements
Module: fu_alu_issue

Interface
REQ-001 SHALL have parameter TAG_W, default 4, meaning producer-tag width.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port disp_valid  input  1  dispatcher offers an op.
REQ-005 SHALL have port disp_ready  output  1  block can accept an op.
REQ-006 SHALL have port disp_ctrl  input  4  ALU control code, passed to FU unchanged.
REQ-007 SHALL have ports disp_a, disp_b  input  32 each  operand values, valid when matching rdy flag is 1.
REQ-008 SHALL have ports disp_a_rdy, disp_b_rdy  input  1 each  operand already available.
REQ-009 SHALL have ports disp_a_tag, disp_b_tag  input  TAG_W each  producer tag when operand not ready.
REQ-010 SHALL have port disp_dst_tag  input  TAG_W  tag broadcast with this op's result.
REQ-011 SHALL have ports cdb_valid (1), cdb_tag (TAG_W), cdb_data (32)  input  result bus snooped for operands.
REQ-012 SHALL have ports fu_en (1), fu_ctrl (4), fu_a (32), fu_b (32)  output  drive to ALU functional unit.
REQ-013 SHALL have ports fu_finish (1), fu_res (32), fu_overflow (1)  input  from ALU functional unit.
REQ-014 SHALL have ports wb_valid (1), wb_tag (TAG_W), wb_data (32), wb_overflow (1)  output  writeback request.
REQ-015 SHALL have port wb_ready  input  1  writeback accepted.

Function
REQ-016 SHALL implement states IDLE, WAIT_OPS, EXEC, WB; one op in flight at a time.
REQ-017 SHALL drive disp_ready = 1 only in IDLE (combinational from state).
REQ-018 SHALL, on disp_valid & disp_ready at a clock edge, register ctrl, dst_tag, both operands, rdy flags and tags, and move to WAIT_OPS.
REQ-019 SHALL, in the accept cycle, set a not-ready operand ready with cdb_data when cdb_valid and cdb_tag equals its tag (same-cycle bypass).
REQ-020 SHALL, in WAIT_OPS, capture cdb_data into each registered not-ready operand whose tag matches cdb_tag while cdb_valid; both operands may capture in the same cycle.
REQ-021 SHALL never overwrite an operand already marked ready.
REQ-022 SHALL assert fu_en for exactly one cycle, in WAIT_OPS when both registered rdy flags are 1, and move to EXEC at that edge.
REQ-023 SHALL hold fu_ctrl/fu_a/fu_b equal to registered values whenever fu_en = 1; op with both operands ready at accept issues the next cycle (fu_en 1 cycle after accept).
REQ-024 SHALL, in EXEC, wait for fu_finish; on fu_finish = 1 register fu_res and fu_overflow and move to WB.
REQ-025 SHALL ignore fu_finish in every state other than EXEC.
REQ-026 SHALL, in WB, assert wb_valid with wb_tag = dst_tag, wb_data/wb_overflow from captured result, held stable until wb_ready.
REQ-027 SHALL, on wb_valid & wb_ready, return to IDLE; next accept earliest one cycle later (no same-cycle accept).
REQ-028 SHALL not snoop CDB in EXEC or WB, and not snoop its own writeback.
REQ-029 SHALL issue any ctrl code unmodified, including undefined codes.
REQ-030 SHALL give minimum latency accept -> wb_valid of 3 cycles with both operands ready and fu_finish one cycle after fu_en.

Reset
REQ-031 SHALL, on rst = 1 at any time, asynchronously enter IDLE and clear all registers.
REQ-032 SHALL hold outputs during reset: disp_ready 0 while rst = 1 then 1 in IDLE, fu_en 0, fu_ctrl/fu_a/fu_b 0, wb_valid 0, wb_tag/wb_data/wb_overflow 0.
REQ-033 SHALL discard an in-flight op on reset mid-operation; a late fu_finish after reset is ignored.

Verification
REQ-034 Ready operands: accept ctrl=0001, a=5, b=7 both rdy -> fu_en next cycle with fu_a=5, fu_b=7; fu_finish with fu_res=12 -> wb_valid next cycle, wb_data=12, wb_tag=dst_tag.
REQ-035 CDB wakeup: accept a rdy=3, b tag=2 not rdy; cdb_valid tag=5 ignored; cdb tag=2 data=9 -> fu_en next cycle, fu_b=9.
REQ-036 Same-cycle bypass and double match: accept both tags=4 with cdb_valid tag=4 data=0xFFFFFFFF in accept cycle -> fu_en next cycle, fu_a=fu_b=0xFFFFFFFF.
REQ-037 Writeback backpressure: wb_ready=0 for 5 cycles -> wb_valid and wb_data stable, disp_ready 0; wb_ready=1 -> IDLE, disp_ready 1 next cycle.
REQ-038 Reset mid-EXEC: rst pulsed after fu_en, then fu_finish=1 -> no wb_valid, disp_ready 1, all outputs 0.
REQ-039 Overflow pass-through: fu_overflow=1 with fu_finish -> wb_overflow=1 while wb_valid.

Source files
------------

// File: rtl/fu_alu_issue.sv
// Single-entry issue slot in front of an ALU functional unit.
// Holds one op, collects missing operands from the CDB, issues the op to the
// FU, captures the FU result and presents it for writeback.
module fu_alu_issue #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [3:0]       disp_ctrl,
    input  logic [31:0]      disp_a,
    input  logic [31:0]      disp_b,
    input  logic             disp_a_rdy,
    input  logic             disp_b_rdy,
    input  logic [TAG_W-1:0] disp_a_tag,
    input  logic [TAG_W-1:0] disp_b_tag,
    input  logic [TAG_W-1:0] disp_dst_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             fu_en,
    output logic [3:0]       fu_ctrl,
    output logic [31:0]      fu_a,
    output logic [31:0]      fu_b,
    input  logic             fu_finish,
    input  logic [31:0]      fu_res,
    input  logic             fu_overflow,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    output logic             wb_overflow,
    input  logic             wb_ready
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OPS,
        EXEC,
        WB
    } state_t;

    state_t           state;
    logic [3:0]       ctrl_q;
    logic [TAG_W-1:0] dst_q;
    logic [TAG_W-1:0] a_tag_q;
    logic [TAG_W-1:0] b_tag_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             a_rdy_q;
    logic             b_rdy_q;
    logic [31:0]      res_q;
    logic             ovf_q;

    logic accept;
    logic a_hit_disp;
    logic b_hit_disp;
    logic a_hit;
    logic b_hit;
    logic issue;
    logic in_wb;

    // Handshake decode and CDB tag matching for incoming and held operands
    always_comb begin
        disp_ready = (state == IDLE) && !rst;
        accept     = disp_valid && disp_ready;
        a_hit_disp = !disp_a_rdy && cdb_valid && (cdb_tag == disp_a_tag);
        b_hit_disp = !disp_b_rdy && cdb_valid && (cdb_tag == disp_b_tag);
        a_hit      = !a_rdy_q && cdb_valid && (cdb_tag == a_tag_q);
        b_hit      = !b_rdy_q && cdb_valid && (cdb_tag == b_tag_q);
        issue      = (state == WAIT_OPS) && a_rdy_q && b_rdy_q;
        in_wb      = (state == WB);
    end

    // FU and writeback outputs are forced to zero outside their valid windows
    always_comb begin
        fu_en       = issue;
        fu_ctrl     = issue ? ctrl_q : '0;
        fu_a        = issue ? a_q : '0;
        fu_b        = issue ? b_q : '0;
        wb_valid    = in_wb;
        wb_tag      = in_wb ? dst_q : '0;
        wb_data     = in_wb ? res_q : '0;
        wb_overflow = in_wb ? ovf_q : '0;
    end

    // Issue-slot FSM: accept, operand wakeup, execute, writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ctrl_q  <= '0;
            dst_q   <= '0;
            a_tag_q <= '0;
            b_tag_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_rdy_q <= 1'b0;
            b_rdy_q <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ctrl_q  <= disp_ctrl;
                        dst_q   <= disp_dst_tag;
                        a_tag_q <= disp_a_tag;
                        b_tag_q <= disp_b_tag;
                        a_q     <= a_hit_disp ? cdb_data : disp_a;
                        b_q     <= b_hit_disp ? cdb_data : disp_b;
                        a_rdy_q <= disp_a_rdy || a_hit_disp;
                        b_rdy_q <= disp_b_rdy || b_hit_disp;
                        state   <= WAIT_OPS;
                    end
                end
                WAIT_OPS: begin
                    if (issue) begin
                        state <= EXEC;
                    end
                    if (a_hit) begin
                        a_q     <= cdb_data;
                        a_rdy_q <= 1'b1;
                    end
                    if (b_hit) begin
                        b_q     <= cdb_data;
                        b_rdy_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (fu_finish) begin
                        res_q <= fu_res;
                        ovf_q <= fu_overflow;
                        state <= WB;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_alu_issue.sv
// Bench for fu_alu_issue: directed ops with hand-computed expectations pushed
// into scoreboard queues; a negedge monitor pops them when fu_en or a
// writeback handshake appears.
module tb_fu_alu_issue;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             disp_valid;
    logic             disp_ready;
    logic [3:0]       disp_ctrl;
    logic [31:0]      disp_a;
    logic [31:0]      disp_b;
    logic             disp_a_rdy;
    logic             disp_b_rdy;
    logic [TAG_W-1:0] disp_a_tag;
    logic [TAG_W-1:0] disp_b_tag;
    logic [TAG_W-1:0] disp_dst_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             fu_en;
    logic [3:0]       fu_ctrl;
    logic [31:0]      fu_a;
    logic [31:0]      fu_b;
    logic             fu_finish;
    logic [31:0]      fu_res;
    logic             fu_overflow;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             wb_overflow;
    logic             wb_ready;

    fu_alu_issue #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_ctrl   (disp_ctrl),
        .disp_a      (disp_a),
        .disp_b      (disp_b),
        .disp_a_rdy  (disp_a_rdy),
        .disp_b_rdy  (disp_b_rdy),
        .disp_a_tag  (disp_a_tag),
        .disp_b_tag  (disp_b_tag),
        .disp_dst_tag(disp_dst_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .fu_en       (fu_en),
        .fu_ctrl     (fu_ctrl),
        .fu_a        (fu_a),
        .fu_b        (fu_b),
        .fu_finish   (fu_finish),
        .fu_res      (fu_res),
        .fu_overflow (fu_overflow),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .wb_overflow (wb_overflow),
        .wb_ready    (wb_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } fu_exp_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             ovf;
    } wb_exp_t;

    fu_exp_t fu_q[$];
    wb_exp_t wb_q[$];

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; caller sets up the CDB beforehand
    task automatic send(input logic [3:0] ctrl,
                        input logic [31:0] a, input logic ardy, input logic [TAG_W-1:0] atag,
                        input logic [31:0] b, input logic brdy, input logic [TAG_W-1:0] btag,
                        input logic [TAG_W-1:0] dst);
        disp_valid   = 1'b1;
        disp_ctrl    = ctrl;
        disp_a       = a;
        disp_a_rdy   = ardy;
        disp_a_tag   = atag;
        disp_b       = b;
        disp_b_rdy   = brdy;
        disp_b_tag   = btag;
        disp_dst_tag = dst;
        chk("disp_ready_before_accept", {31'b0, disp_ready}, 32'd1);
        tick();
        disp_valid = 1'b0;
        disp_ctrl  = '0;
        disp_a     = '0;
        disp_b     = '0;
        disp_a_rdy = 1'b0;
        disp_b_rdy = 1'b0;
    endtask

    // Drive fu_finish for exactly one cycle (caller must be in EXEC)
    task automatic finish(input logic [31:0] res, input logic ovf);
        fu_finish   = 1'b1;
        fu_res      = res;
        fu_overflow = ovf;
        tick();
        fu_finish   = 1'b0;
        fu_res      = '0;
        fu_overflow = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fu_en"},       {31'b0, fu_en}, 32'd0);
        chk({tag, "_fu_ctrl"},     {28'b0, fu_ctrl}, 32'd0);
        chk({tag, "_fu_a"},        fu_a, 32'd0);
        chk({tag, "_fu_b"},        fu_b, 32'd0);
        chk({tag, "_wb_valid"},    {31'b0, wb_valid}, 32'd0);
        chk({tag, "_wb_tag"},      {28'b0, wb_tag}, 32'd0);
        chk({tag, "_wb_data"},     wb_data, 32'd0);
        chk({tag, "_wb_overflow"}, {31'b0, wb_overflow}, 32'd0);
    endtask

    // Monitor: compare every FU issue and writeback handshake against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (fu_en) begin
                if (fu_q.size() == 0) begin
                    chk("fu_en_unexpected", 32'd1, 32'd0);
                end else begin
                    fu_exp_t e;
                    e = fu_q.pop_front();
                    chk("sb_fu_ctrl", {28'b0, fu_ctrl}, {28'b0, e.ctrl});
                    chk("sb_fu_a", fu_a, e.a);
                    chk("sb_fu_b", fu_b, e.b);
                end
            end
            if (wb_valid && wb_ready) begin
                if (wb_q.size() == 0) begin
                    chk("wb_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    wb_exp_t w;
                    w = wb_q.pop_front();
                    chk("sb_wb_tag", {28'b0, wb_tag}, {28'b0, w.tag});
                    chk("sb_wb_data", wb_data, w.data);
                    chk("sb_wb_overflow", {31'b0, wb_overflow}, {31'b0, w.ovf});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        disp_valid = 1'b0; disp_ctrl = '0; disp_a = '0; disp_b = '0;
        disp_a_rdy = 1'b0; disp_b_rdy = 1'b0;
        disp_a_tag = '0; disp_b_tag = '0; disp_dst_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        fu_finish = 1'b0; fu_res = '0; fu_overflow = 1'b0;
        wb_ready = 1'b1;

        // Reset state
        tick();
        chk("rst_disp_ready", {31'b0, disp_ready}, 32'd0);
        chk_all_zero("rst");
        rst = 1'b0;
        tick();
        chk("idle_disp_ready", {31'b0, disp_ready}, 32'd1);

        // fu_finish while idle is ignored
        fu_finish = 1'b1; fu_res = 32'hDEAD_BEEF;
        tick();
        fu_finish = 1'b0; fu_res = '0;
        chk("idle_finish_no_wb", {31'b0, wb_valid}, 32'd0);
        chk("idle_finish_ready", {31'b0, disp_ready}, 32'd1);

        // Both operands ready: 5 + 7 = 12
        fu_q.push_back('{ctrl: 4'h1, a: 32'd5, b: 32'd7});
        wb_q.push_back('{tag: 4'd3, data: 32'd12, ovf: 1'b0});
        send(4'h1, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
        chk("t1_fu_en_next", {31'b0, fu_en}, 32'd1);
        chk("t1_busy", {31'b0, disp_ready}, 32'd0);
        tick();
        chk("t1_fu_en_once", {31'b0, fu_en}, 32'd0);
        finish(32'd12, 1'b0);
        chk("t1_latency_wb", {31'b0, wb_valid}, 32'd1);
        tick();
        chk("t1_back_idle", {31'b0, disp_ready}, 32'd1);

        // CDB wakeup of operand b; tag 5 matches a's stale tag but a is ready
        fu_q.push_back('{ctrl: 4'h2, a: 32'd3, b: 32'd9});
        wb_q.push_back('{tag: 4'd6, data: 32'h0000_1234, ovf: 1'b0});
        send(4'h2, 32'd3, 1'b1, 4'd5, 32'd0, 1'b0, 4'd2, 4'd6);
        chk("t2_wait", {31'b0, fu_en}, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'd77;
        fu_finish = 1'b1; fu_res = 32'hBAD;
        tick();
        fu_finish = 1'b0; fu_res = '0;
        chk("t2_tag5_ignored", {31'b0, fu_en}, 32'd0);
        chk("t2_finish_ignored", {31'b0, wb_valid}, 32'd0);
        cdb_tag = 4'd2; cdb_data = 32'd9;
        tick();
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        chk("t2_wakeup_fu_en", {31'b0, fu_en}, 32'd1);
        tick();
        finish(32'h0000_1234, 1'b0);
        tick();

        // Same-cycle bypass into both operands, undefined ctrl code, overflow
        fu_q.push_back('{ctrl: 4'hF, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF});
        wb_q.push_back('{tag: 4'd9, data: 32'h0000_0000, ovf: 1'b1});
        cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_data = 32'hFFFF_FFFF;
        send(4'hF, 32'd0, 1'b0, 4'd4, 32'd0, 1'b0, 4'd4, 4'd9);
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        chk("t3_bypass_fu_en", {31'b0, fu_en}, 32'd1);
        tick();
        finish(32'h0000_0000, 1'b1);
        chk("t3_wb_overflow", {31'b0, wb_overflow}, 32'd1);
        tick();

        // Writeback backpressure
        wb_ready = 1'b0;
        fu_q.push_back('{ctrl: 4'h3, a: 32'd10, b: 32'd20});
        wb_q.push_back('{tag: 4'd12, data: 32'd30, ovf: 1'b0});
        send(4'h3, 32'd10, 1'b1, 4'd0, 32'd20, 1'b1, 4'd0, 4'd12);
        tick();
        finish(32'd30, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {31'b0, wb_valid}, 32'd1);
            chk("t4_hold_data", wb_data, 32'd30);
            chk("t4_hold_tag", {28'b0, wb_tag}, 32'd12);
            chk("t4_no_accept", {31'b0, disp_ready}, 32'd0);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        chk("t4_release_ready", {31'b0, disp_ready}, 32'd1);
        chk("t4_release_wb", {31'b0, wb_valid}, 32'd0);

        // Reset in EXEC, then a late fu_finish
        fu_q.push_back('{ctrl: 4'h4, a: 32'd1, b: 32'd2});
        send(4'h4, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd1);
        tick();
        rst = 1'b1;
        #2;
        chk("t5_rst_disp_ready", {31'b0, disp_ready}, 32'd0);
        rst = 1'b0;
        #1;
        finish(32'd99, 1'b1);
        chk("t5_ready_after_rst", {31'b0, disp_ready}, 32'd1);
        chk_all_zero("t5");
        tick();
        chk("t5_still_no_wb", {31'b0, wb_valid}, 32'd0);

        chk("sb_fu_drained", fu_q.size(), 32'd0);
        chk("sb_wb_drained", wb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
